serial_nbit_adder: RTL and testbench
====================================

SERIAL_NBIT_ADDER -- requirements
Module: serial_nbit_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand and sum width in bits, minimum 2.
REQ-002 The block SHALL have parameter DIGIT, default 1: bits added per clock cycle; WIDTH % DIGIT != 0 SHALL be an elaboration error.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic on rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port valid_i, input, 1 bit: operand request valid.
REQ-006 The block SHALL have port ready_o, output, 1 bit: block can accept a request.
REQ-007 The block SHALL have ports a_i and b_i, input, WIDTH bits: operands.
REQ-008 The block SHALL have port c_i, input, 1 bit: carry-in, used in add mode only.
REQ-009 The block SHALL have port sub_i, input, 1 bit: 0 = a+b+c_i, 1 = a-b.
REQ-010 The block SHALL have port valid_o, output, 1 bit: result valid.
REQ-011 The block SHALL have port ready_i, input, 1 bit: consumer accepts result.
REQ-012 The block SHALL have port sum_o, output, WIDTH bits: result.
REQ-013 The block SHALL have port c_o, output, 1 bit: carry-out (in sub mode, 1 = no borrow).
REQ-014 The block SHALL have port ovf_o, output, 1 bit: two's-complement signed overflow.

Function
REQ-015 The block SHALL have FSM states IDLE, RUN and DONE; ready_o = 1 only in IDLE, and valid_o = 1 only in DONE.
REQ-016 On valid_i && ready_o at a clock edge, the block SHALL capture a_i, b_i and sub_i, enter RUN, and clear its cycle counter; valid_i outside IDLE SHALL be ignored.
REQ-017 The block SHALL use effective operand b' = sub ? ~b : b and initial carry = sub ? 1 : c_i.
REQ-018 Each RUN cycle SHALL add the DIGIT least-significant unprocessed bits of a and b' plus the registered carry, using a DIGIT-bit ripple chain of full-adder cells.
REQ-019 Each RUN cycle SHALL register the DIGIT result bits into the sum shift register, shift the operands right by DIGIT, and register the carry.
REQ-020 RUN SHALL last exactly N = WIDTH/DIGIT cycles; after the Nth RUN edge the block SHALL enter DONE.
REQ-021 Capture at edge k SHALL give valid_o = 1 after edge k+N; DIGIT = WIDTH SHALL give a single RUN cycle.
REQ-022 On the final digit, c_o SHALL be the carry out of bit WIDTH-1, and ovf_o SHALL be carry-into-bit-(WIDTH-1) XOR carry-out-of-bit-(WIDTH-1).
REQ-023 In DONE, sum_o, c_o and ovf_o SHALL stay stable until valid_o && ready_i; at that edge the block SHALL return to IDLE, with ready_o = 1 the following cycle (no same-cycle re-accept).
REQ-024 Outside DONE, sum_o, c_o and ovf_o SHALL hold their last completed result; their contents are not valid to consumers.
REQ-025 ready_i SHALL have no effect outside DONE.
REQ-026 Operand inputs SHALL not be sampled after capture; input changes during RUN or DONE SHALL not affect the result.

Reset
REQ-027 While rst_ni = 0 at a clock edge, the block SHALL enter IDLE and clear the counter, carry, shift registers and outputs: ready_o = 1 (from the edge after rst_ni rises), valid_o = 0, sum_o = 0, c_o = 0, ovf_o = 0.
REQ-028 Reset asserted in RUN or DONE SHALL abort the operation and discard the result, with no valid_o pulse.
REQ-029 Reset SHALL take priority over every handshake event in the same cycle.

Verification
REQ-030 WIDTH=8, DIGIT=1, add 0x7F+0x01, c_i=0 -> after 8 RUN cycles: sum_o=0x80, c_o=0, ovf_o=1.
REQ-031 WIDTH=8, DIGIT=1, add 0xFF+0x01, c_i=1 -> sum_o=0x01, c_o=1, ovf_o=0.
REQ-032 WIDTH=8, sub 0x05-0x07 -> sum_o=0xFE, c_o=0, ovf_o=0; sub 0x80-0x01 -> sum_o=0x7F, c_o=1, ovf_o=1.
REQ-033 ready_i held low 5 cycles in DONE, with a_i/b_i toggling and valid_i high -> valid_o and the result stay constant, ready_o stays 0, and no new capture occurs.
REQ-034 rst_ni low for 1 cycle at RUN cycle 3 -> next cycle IDLE, ready_o=1, valid_o=0; a following request completes correctly.
REQ-035 WIDTH=16, DIGIT=4, 0xFFFF+0x0001 -> valid_o exactly 4 cycles after capture, sum_o=0x0000, c_o=1; random add/sub matches the reference model for 1000 vectors.

Source files
------------

// File: rtl/serial_nbit_adder.sv
// -----------------------------------------------------------------------------
// serial_nbit_adder
//   Digit-serial adder/subtractor. A request is captured in IDLE, then the
//   operands are consumed DIGIT bits per clock through a DIGIT-wide ripple chain
//   of full-adder cells. After WIDTH/DIGIT RUN cycles the result is presented
//   in DONE and held until the consumer accepts it.
//
// Parameters
//   WIDTH   operand / sum width in bits (>= 2)
//   DIGIT   bits processed per clock; must divide WIDTH
//
// Ports
//   clk_i    clock, all logic on the rising edge
//   rst_ni   synchronous active-low reset
//   valid_i  request valid            ready_o  request can be accepted (IDLE)
//   a_i,b_i  operands                 c_i      carry-in (add mode only)
//   sub_i    0: a+b+c_i, 1: a-b
//   valid_o  result valid (DONE)      ready_i  consumer accepts result
//   sum_o    result                   c_o      carry-out (sub: 1 = no borrow)
//   ovf_o    two's-complement signed overflow
// -----------------------------------------------------------------------------
module serial_nbit_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_o,
  output logic             ovf_o
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("serial_nbit_adder: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] a_reg;     // remaining bits of a, LSB first
  logic [WIDTH-1:0] b_reg;     // remaining bits of effective b (inverted for sub)
  logic [WIDTH-1:0] sum_reg;   // result digits enter at the top and shift down

  logic [DIGIT-1:0] digit_sum;
  logic [DIGIT:0]   cy;        // cy[i] is the carry into cell i of this digit

  assign cy[0] = carry_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DIGIT; gi++) begin : g_fa
      assign digit_sum[gi] = a_reg[gi] ^ b_reg[gi] ^ cy[gi];
      assign cy[gi+1]      = (a_reg[gi] & b_reg[gi]) | (cy[gi] & (a_reg[gi] ^ b_reg[gi]));
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      ready_o   <= 1'b1;
      valid_o   <= 1'b0;
      sum_o     <= '0;
      c_o       <= 1'b0;
      ovf_o     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (valid_i) begin
            // Subtraction is a + ~b + 1, so only b and the initial carry differ.
            a_reg     <= a_i;
            b_reg     <= sub_i ? ~b_i : b_i;
            carry_reg <= sub_i ? 1'b1 : c_i;
            cnt_reg   <= '0;
            ready_o   <= 1'b0;
            state_reg <= RUN;
          end
        end

        RUN: begin
          a_reg     <= a_reg >> DIGIT;
          b_reg     <= b_reg >> DIGIT;
          // Prepend the new digit and drop the lowest DIGIT bits; after N
          // cycles the first digit has reached bit 0.
          sum_reg   <= WIDTH'({digit_sum, sum_reg} >> DIGIT);
          carry_reg <= cy[DIGIT];
          cnt_reg   <= cnt_reg + CW'(1);
          if (cnt_reg == LAST) begin
            sum_o     <= WIDTH'({digit_sum, sum_reg} >> DIGIT);
            c_o       <= cy[DIGIT];
            // Top cell of the final digit is bit WIDTH-1 of the word.
            ovf_o     <= cy[DIGIT] ^ cy[DIGIT-1];
            valid_o   <= 1'b1;
            state_reg <= DONE;
          end
        end

        DONE: begin
          if (ready_i) begin
            valid_o   <= 1'b0;
            ready_o   <= 1'b1;
            state_reg <= IDLE;
          end
        end

        default: begin
          valid_o   <= 1'b0;
          ready_o   <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_nbit_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_nbit_adder
//   Drives two instances (WIDTH=8/DIGIT=1 and WIDTH=16/DIGIT=4) with directed
//   and random add/sub requests and compares against an arithmetic model.
// -----------------------------------------------------------------------------
module tb_serial_nbit_adder;

  logic clk = 1'b0;
  logic rst_n;
  logic ready_in;
  logic c_in;
  logic sub;

  logic        v8, rdy8, vo8, co8, ov8;
  logic [7:0]  a8, b8, s8;
  logic        v16, rdy16, vo16, co16, ov16;
  logic [15:0] a16, b16, s16;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  serial_nbit_adder #(.WIDTH(8), .DIGIT(1)) u_add8 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v8), .ready_o(rdy8),
    .a_i(a8), .b_i(b8), .c_i(c_in), .sub_i(sub),
    .valid_o(vo8), .ready_i(ready_in), .sum_o(s8), .c_o(co8), .ovf_o(ov8)
  );

  serial_nbit_adder #(.WIDTH(16), .DIGIT(4)) u_add16 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v16), .ready_o(rdy16),
    .a_i(a16), .b_i(b16), .c_i(c_in), .sub_i(sub),
    .valid_o(vo16), .ready_i(ready_in), .sum_o(s16), .c_o(co16), .ovf_o(ov16)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic logic dut_ready(input int w);
    return (w == 8) ? rdy8 : rdy16;
  endfunction
  function automatic logic dut_valid(input int w);
    return (w == 8) ? vo8 : vo16;
  endfunction
  function automatic logic [15:0] dut_sum(input int w);
    return (w == 8) ? {8'h00, s8} : s16;
  endfunction
  function automatic logic dut_c(input int w);
    return (w == 8) ? co8 : co16;
  endfunction
  function automatic logic dut_ovf(input int w);
    return (w == 8) ? ov8 : ov16;
  endfunction

  task automatic drive(input int w, input logic v, input logic [15:0] a, input logic [15:0] b);
    if (w == 8) begin
      v8 = v; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      v16 = v; a16 = a; b16 = b;
    end
  endtask

  // Reference: unsigned total gives sum and carry; overflow is the signed
  // result falling outside the representable range.
  task automatic ref_model(input int w, input longint a, input longint b, input logic c,
                           input logic s, output logic [15:0] e_sum, output logic e_c,
                           output logic e_ovf);
    longint full, half, total, sa, sb, sr;
    full  = longint'(1) << w;
    half  = full / 2;
    total = s ? (a - b + full) : (a + b + longint'(c));
    e_sum = 16'(total % full);
    e_c   = (total >= full);
    sa    = (a >= half) ? a - full : a;
    sb    = (b >= half) ? b - full : b;
    sr    = s ? (sa - sb) : (sa + sb + longint'(c));
    e_ovf = (sr < -half) || (sr > half - 1);
  endtask

  task automatic do_op(input int w, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic s, input int stall);
    logic [15:0] e_sum;
    logic        e_c, e_ovf;
    int          n, guard, lat;
    n = (w == 8) ? 8 : 4;
    ref_model(w, longint'(a), longint'(b), c, s, e_sum, e_c, e_ovf);

    @(negedge clk);
    guard = 0;
    while (!dut_ready(w) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_val("ready_idle", dut_ready(w), 1'b1);
    drive(w, 1'b1, a, b);
    c_in = c;
    sub  = s;
    @(negedge clk);
    // Scramble the inputs after capture; the result must not depend on them.
    drive(w, 1'b0, 16'($urandom), 16'($urandom));
    c_in = 1'($urandom);
    sub  = 1'($urandom);
    check_val("ready_busy", dut_ready(w), 1'b0);

    lat = 0;
    while (!dut_valid(w) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_val("latency", lat, n);
    check_val("sum", dut_sum(w), e_sum);
    check_val("carry", dut_c(w), e_c);
    check_val("ovf", dut_ovf(w), e_ovf);

    for (int i = 0; i < stall; i++) begin
      drive(w, 1'b1, 16'($urandom), 16'($urandom));
      @(negedge clk);
      check_val("stall_valid", dut_valid(w), 1'b1);
      check_val("stall_ready", dut_ready(w), 1'b0);
      check_val("stall_sum", {dut_sum(w), dut_c(w), dut_ovf(w)}, {e_sum, e_c, e_ovf});
    end
    drive(w, 1'b0, 16'h0000, 16'h0000);

    ready_in = 1'b1;
    @(negedge clk);
    ready_in = 1'b0;
    check_val("valid_clr", dut_valid(w), 1'b0);
    check_val("ready_back", dut_ready(w), 1'b1);
    $display("op w=%0d %s a=%h b=%h c=%0b -> sum=%h c_o=%0b ovf=%0b (exp %h %0b %0b) lat=%0d",
             w, s ? "sub" : "add", a, b, c, dut_sum(w), dut_c(w), dut_ovf(w),
             e_sum, e_c, e_ovf, lat);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    rst_n = 1'b0; ready_in = 1'b0; c_in = 1'b0; sub = 1'b0;
    drive(8, 1'b1, 16'h00AA, 16'h0055);      // valid during reset must be ignored
    drive(16, 1'b1, 16'h1234, 16'h5678);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive(8, 1'b0, 16'h0000, 16'h0000);
    drive(16, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    check_val("rst_ready8", rdy8, 1'b1);
    check_val("rst_ready16", rdy16, 1'b1);
    check_val("rst_valid", {vo8, vo16}, 2'b00);
    check_val("rst_sum8", s8, 8'h00);
    check_val("rst_sum16", s16, 16'h0000);
    check_val("rst_flags", {co8, ov8, co16, ov16}, 4'b0000);

    // Directed corner cases
    do_op(8, 16'h007F, 16'h0001, 1'b0, 1'b0, 0);
    do_op(8, 16'h00FF, 16'h0001, 1'b1, 1'b0, 0);
    do_op(8, 16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    do_op(8, 16'h0080, 16'h0001, 1'b0, 1'b1, 0);
    do_op(8, 16'h003C, 16'h0042, 1'b1, 1'b0, 5);
    do_op(16, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    do_op(16, 16'h8000, 16'h0001, 1'b0, 1'b1, 2);

    // Reset during RUN cycle 3 aborts the operation
    @(negedge clk);
    drive(8, 1'b1, 16'h0012, 16'h0034);
    @(negedge clk);
    drive(8, 1'b0, 16'h0000, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_val("abort_ready", rdy8, 1'b1);
    check_val("abort_valid", vo8, 1'b0);
    check_val("abort_out", {s8, co8, ov8}, 10'h000);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (vo8) pulses++;
    end
    check_val("abort_no_pulse", pulses, 0);
    $display("op w=8 reset abort during RUN, valid pulses after=%0d", pulses);
    do_op(8, 16'h0064, 16'h0023, 1'b0, 1'b0, 0);

    // Random vectors
    for (int i = 0; i < 1000; i++)
      do_op(16, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 1)));
    for (int i = 0; i < 100; i++)
      do_op(8, {8'h00, 8'($urandom)}, {8'h00, 8'($urandom)}, 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
